// File: rtl/pc_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: PC+4 adder, instruction
// memory, branch/jump resolution, hazard unit and the IF/ID consumer.
// The fetch stage itself connects through the slave modport; whoever drives
// the redirect/stall controls and reads the IF/ID register uses master.
interface pc_fetch_stage_if;
    logic [31:0] PCAddResult;
    logic [31:0] Instruction;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic        Halt;

    logic [31:0] PCResult;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic        MisalignFault;
    logic [31:0] FetchCount;

    modport master (
        output PCAddResult, Instruction, BranchTaken, BranchTarget,
               Jump, JumpTarget, Stall, Halt,
        input  PCResult, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               Halted, MisalignFault, FetchCount
    );

    modport slave (
        input  PCAddResult, Instruction, BranchTaken, BranchTarget,
               Jump, JumpTarget, Stall, Halt,
        output PCResult, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               Halted, MisalignFault, FetchCount
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: owns the architectural PC, picks the next PC
// (jump > branch > stall hold > PC+4) and loads the IF/ID pipeline register.
// A short BOOT phase follows reset; HALT and FAULT (misaligned redirect
// target) are terminal until the next reset.
// Optional build macro FETCH_COUNT_EN: when defined, FetchCount counts
// instructions loaded into IF/ID (saturating); otherwise it is tied to 0.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    pc_fetch_stage_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] p4_q, p4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        advance;

    // Decode the redirect request and whether this cycle is a plain PC+4 fetch.
    always_comb begin
        redirect        = bus.Jump | bus.BranchTaken;
        redirect_target = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
        advance         = (state_q == RUN) && !bus.Halt && !redirect && !bus.Stall;
    end

    // Next-state and next-register logic; everything holds unless a case says otherwise.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        p4_d       = p4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = RUN;
                    boot_cnt_d = 4'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    state_d = HALT;
                    ins_d   = 32'd0;
                    p4_d    = 32'd0;
                    valid_d = 1'b0;
                end else if (redirect) begin
                    ins_d   = 32'd0;
                    p4_d    = 32'd0;
                    valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (advance) begin
                    pc_d    = bus.PCAddResult;
                    ins_d   = bus.Instruction;
                    p4_d    = bus.PCAddResult;
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and boot counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // PC, IF/ID pipeline register and sticky fault flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_PC;
            ins_q   <= 32'd0;
            p4_q    <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            p4_q    <= p4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    // Count every real instruction loaded into IF/ID, sticking at all-ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= 32'd0;
        end else if (advance && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.FetchCount = count_q;
`else
    assign bus.FetchCount = 32'd0;
`endif

    assign bus.PCResult          = pc_q;
    assign bus.IF_ID_Instruction = ins_q;
    assign bus.IF_ID_PCPlus4     = p4_q;
    assign bus.IF_ID_Valid       = valid_q;
    assign bus.Halted            = (state_q == HALT);
    assign bus.MisalignFault     = fault_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage: a table of per-cycle input/expected-output
// records, a queue of expected results filled as stimulus is driven and
// drained after each clock edge, plus hand-written reset sequences.
module tb_pc_fetch_stage;

    logic Clk = 1'b0;
    logic Reset;

    // Free-running 10-time-unit clock.
    always #5 Clk = ~Clk;

    pc_fetch_stage_if bus ();

    pc_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .BOOT_CYCLES (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic        j;
        logic [31:0] jt;
        logic        b;
        logic [31:0] bt;
        logic        s;
        logic        h;
        logic [31:0] add;
        logic [31:0] ins;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_p4;
        logic        e_v;
        logic        e_h;
        logic        e_f;
        logic        fetch;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        valid;
        logic        halted;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    localparam int NV = 27;

    vec_t        vecs [0:NV-1];
    exp_t        exp_q [$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_count = 32'd0;

    function automatic vec_t mk(
        input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
        input logic s, input logic h, input logic [31:0] add, input logic [31:0] ins,
        input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [31:0] e_p4,
        input logic e_v, input logic e_h, input logic e_f, input logic fetch);
        vec_t v;
        v.j = j;  v.jt = jt;  v.b = b;  v.bt = bt;  v.s = s;  v.h = h;
        v.add = add;  v.ins = ins;
        v.e_pc = e_pc;  v.e_ins = e_ins;  v.e_p4 = e_p4;
        v.e_v = e_v;  v.e_h = e_h;  v.e_f = e_f;  v.fetch = fetch;
        return v;
    endfunction

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.Jump = 1'b0;  bus.JumpTarget = 32'd0;
        bus.BranchTaken = 1'b0;  bus.BranchTarget = 32'd0;
        bus.Stall = 1'b0;  bus.Halt = 1'b0;
        bus.PCAddResult = 32'd0;  bus.Instruction = 32'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bus.Jump = v.j;  bus.JumpTarget = v.jt;
        bus.BranchTaken = v.b;  bus.BranchTarget = v.bt;
        bus.Stall = v.s;  bus.Halt = v.h;
        bus.PCAddResult = v.add;  bus.Instruction = v.ins;
`ifdef FETCH_COUNT_EN
        if (v.fetch && model_count != 32'hFFFF_FFFF) model_count = model_count + 32'd1;
`endif
        e.pc = v.e_pc;  e.ins = v.e_ins;  e.p4 = v.e_p4;
        e.valid = v.e_v;  e.halted = v.e_h;  e.fault = v.e_f;
        e.count = model_count;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.queue: got empty scoreboard, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_value({tag, ".pc"},     bus.PCResult,                  e.pc);
            check_value({tag, ".ins"},    bus.IF_ID_Instruction,         e.ins);
            check_value({tag, ".p4"},     bus.IF_ID_PCPlus4,             e.p4);
            check_value({tag, ".valid"},  {31'd0, bus.IF_ID_Valid},      {31'd0, e.valid});
            check_value({tag, ".halted"}, {31'd0, bus.Halted},           {31'd0, e.halted});
            check_value({tag, ".fault"},  {31'd0, bus.MisalignFault},    {31'd0, e.fault});
            check_value({tag, ".count"},  bus.FetchCount,                e.count);
        end
    endtask

    task automatic check_reset(input string tag);
        model_count = 32'd0;
        check_value({tag, ".pc"},     bus.PCResult,               32'd0);
        check_value({tag, ".ins"},    bus.IF_ID_Instruction,      32'd0);
        check_value({tag, ".p4"},     bus.IF_ID_PCPlus4,          32'd0);
        check_value({tag, ".valid"},  {31'd0, bus.IF_ID_Valid},   32'd0);
        check_value({tag, ".halted"}, {31'd0, bus.Halted},        32'd0);
        check_value({tag, ".fault"},  {31'd0, bus.MisalignFault}, 32'd0);
        check_value({tag, ".count"},  bus.FetchCount,             32'd0);
    endtask

    task automatic run_table(input int lo, input int hi, input bit release_first);
        for (int i = lo; i <= hi; i++) begin
            @(negedge Clk);
            if (release_first && i == lo) Reset = 1'b1;
            applyStimulus(vecs[i]);
            @(posedge Clk);
            #1;
            checkOutput($sformatf("v%0d", i));
        end
    endtask

    initial begin
        // run A: boot, fetch, stall, redirects, wrap, misaligned fault
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h8, 32'h1111_1111, 32'h8, 32'h1111_1111, 32'h8, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 32'hC, 32'h2222_2222, 32'hC, 32'h2222_2222, 32'hC, 1, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'h10, 32'h3333_3333, 32'h10, 32'h3333_3333, 32'h10, 1, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 32'h14, 32'h4444_4444, 32'h10, 32'h3333_3333, 32'h10, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 32'h14, 32'h4444_4444, 32'h10, 32'h3333_3333, 32'h10, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 32'h14, 32'h4444_4444, 32'h10, 32'h3333_3333, 32'h10, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 32'h40, 1, 0, 32'h14, 32'h4444_4444, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 32'h44, 32'h5555_5555, 32'h44, 32'h5555_5555, 32'h44, 1, 0, 0, 1);
        vecs[11] = mk(1, 32'h100, 1, 32'h40, 0, 0, 32'h48, 32'hDEAD_BEEF, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h104, 32'h6666_6666, 32'h104, 32'h6666_6666, 32'h104, 1, 0, 0, 1);
        vecs[13] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h108, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h7777_7777, 32'h0, 32'h7777_7777, 32'h0, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 32'h42, 0, 0, 32'h4, 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        vecs[16] = mk(1, 32'h200, 0, 0, 0, 0, 32'h4, 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        // run B: inputs ignored in BOOT, then halt beats a same-cycle jump
        vecs[18] = mk(1, 32'h300, 0, 0, 0, 0, 32'h4, 32'hBBBB_BBBB, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 32'h4, 32'hBBBB_BBBB, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[20] = mk(1, 32'h20, 0, 0, 0, 0, 32'h4, 32'hBBBB_BBBB, 32'h20, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[21] = mk(1, 32'h80, 0, 0, 0, 1, 32'h24, 32'h8888_8888, 32'h20, 32'h0, 32'h0, 0, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 32'h24, 32'h8888_8888, 32'h20, 32'h0, 32'h0, 0, 1, 0, 0);
        vecs[23] = mk(0, 0, 1, 32'h40, 0, 0, 32'h24, 32'h8888_8888, 32'h20, 32'h0, 32'h0, 0, 1, 0, 0);
        // run C: clean restart after an asynchronous reset
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h9999_9999, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h9999_9999, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h9999_9999, 32'h4, 32'h9999_9999, 32'h4, 1, 0, 0, 1);

        Reset = 1'b0;
        drive_idle();
        #7;
        check_reset("por");
        run_table(0, 17, 1'b1);

        // reset pulse clears the sticky fault
        @(negedge Clk);
        Reset = 1'b0;
        drive_idle();
        #1;
        check_reset("fault_reset");
        run_table(18, 23, 1'b1);

        // reset asserted between edges takes effect before the next edge
        #2;
        Reset = 1'b0;
        #1;
        check_reset("async_reset");
        run_table(24, 26, 1'b1);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL leftover: got %0d entries, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Upstream neighbour of the PC+4 adder.
- Holds the architectural PC, which drives PCResult to the adder and to instruction memory.
- Selects the next PC from PCAddResult (the adder's PC+4), a branch target or a jump target.
- Latches the fetched instruction and PC+4 into the IF/ID pipeline register, with stall, flush, halt and misaligned-target fault handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- BOOT_CYCLES, 2, cycles spent in BOOT after reset release before fetching starts (1..15).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- PCAddResult  in  32  PC+4 from the adder (expected: PCResult+4).
- Instruction  in  32  instruction memory read data at PCResult (combinational).
- BranchTaken  in  1  branch redirect request.
- BranchTarget  in  32  branch destination.
- Jump  in  1  jump redirect request.
- JumpTarget  in  32  jump destination.
- Stall  in  1  hazard-unit stall; freeze PC and IF/ID.
- Halt  in  1  enter HALT state.
- PCResult  out  32  current PC.
- IF_ID_Instruction  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  latched PC+4.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- Halted  out  1  high in HALT.
- MisalignFault  out  1  sticky fault flag.
- FetchCount  out  32  valid-fetch counter.

Behaviour:
- Reset (Reset=0, asynchronous):
  - PCResult=RESET_PC; IF_ID_Instruction=0 (NOP); IF_ID_PCPlus4=0; IF_ID_Valid=0.
  - Halted=0; MisalignFault=0; FetchCount=0; state=BOOT with boot counter cleared.
  - Reset asserted mid-operation aborts everything immediately.
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT:
  - PC held and IF_ID_Valid=0.
  - After BOOT_CYCLES rising edges with Reset=1, move to RUN.
  - All inputs ignored.
- RUN, next-PC priority per cycle (highest first):
  - Jump=1: target=JumpTarget.
  - Otherwise BranchTaken=1: target=BranchTarget.
  - Otherwise, if Stall=1, hold.
  - Otherwise target=PCAddResult.
- Redirect (Jump or BranchTaken):
  - Applies even when Stall=1; redirect wins over stall.
  - IF/ID flushed: Instruction=0, PCPlus4=0, Valid=0.
  - PC loads the target at the next edge.
- Misaligned target:
  - Redirect with target[1:0]≠0: PC is not updated, state goes to FAULT, MisalignFault=1 at that edge, IF/ID flushed.
  - PCAddResult is not alignment-checked.
- Stall=1 with no redirect: PC and all IF/ID outputs hold their values.
- Normal advance (no stall, no redirect):
  - PC<=PCAddResult; IF_ID_Instruction<=Instruction; IF_ID_PCPlus4<=PCAddResult; IF_ID_Valid<=1.
- Halt:
  - Halt=1 in RUN moves to HALT at the next edge. Halt is highest priority: a same-cycle redirect is ignored.
  - IF/ID is flushed on entry; PC is not updated.
  - HALT is exited only by reset; Halted=1 while in HALT.
- FAULT:
  - PC frozen, IF_ID_Valid=0, all inputs ignored.
  - MisalignFault stays 1 until reset.
- Latency:
  - Next PC is visible 1 cycle after the decision.
  - Fetched instruction is visible on IF/ID 1 cycle after PCResult presents its address.
- Arithmetic:
  - PC wraps naturally via PCAddResult (32'hFFFF_FFFC+4 → 0); the block adds nothing itself.

Optional Feature:
- FETCH_COUNT_EN defined:
  - FetchCount increments by 1 on every edge where IF_ID_Valid is loaded with 1.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- FETCH_COUNT_EN undefined:
  - Counter logic is absent and FetchCount is tied to 0.

Test Plan:
- Reset, BOOT, first fetch: RESET_PC=0, BOOT_CYCLES=2; release Reset, drive PCAddResult=PCResult+4 and Instruction=32'h2008_0005.
  - Required: PCResult=0 and IF_ID_Valid=0 for the first 2 edges.
  - Then PC=4, IF_ID_Instruction=32'h2008_0005, IF_ID_PCPlus4=4, Valid=1, FetchCount=1 (FETCH_COUNT_EN defined).
- Stall vs branch: at PC=0x10, Stall=1 for 3 cycles.
  - Required: PC stays 0x10 and IF/ID unchanged.
  - Then with Stall=1 and BranchTaken=1, BranchTarget=0x40: next PC=0x40, IF_ID_Valid=0, IF_ID_Instruction=0.
- Jump over branch: Jump=1, JumpTarget=0x100, BranchTaken=1, BranchTarget=0x40 in the same cycle.
  - Required: PC=0x100.
- Misaligned target: BranchTaken=1, BranchTarget=0x42.
  - Required: PC unchanged, MisalignFault=1, Valid=0.
  - Later Jump to 0x200 is ignored.
  - After Reset pulse low: MisalignFault=0, PC=RESET_PC.
- Halt plus mid-run async reset: Halt=1 with Jump=1 at PC=0x20.
  - Required: Halted=1, PC stays 0x20, Valid=0; further inputs ignored.
  - Assert Reset between clock edges: outputs reach reset values before the next edge.
- Wrap: PC=32'hFFFF_FFFC, PCAddResult=0.
  - Required: next PC=0, IF_ID_PCPlus4=0, Valid=1.
